// File: rtl/libv_pkg.sv
// Shared types for the replay-queue issue controller: FSM states and response encoding.
package libv_pkg;

    typedef enum logic [1:0] {
        ISSUE  = 2'd0,
        DRAIN  = 2'd1,
        REPLAY = 2'd2
    } state_t;

    localparam logic RSP_ACK  = 1'b1;
    localparam logic RSP_NACK = 1'b0;

endpackage

// File: rtl/libv_queue_issue_cnt.sv
// Up/down count of issued-but-unresolved entries with zero and limit flags.
// Latency: count moves one cycle after inc/dec/clr; flags are combinational from the count.
// Backpressure: none; the issuer keeps the count from exceeding N.
module libv_queue_issue_cnt #(
    parameter int N  = 16,
    parameter int CW = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          zero,
    output logic          limit
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + CW'(1);
        end else if (dec && !inc) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign zero  = (cnt == '0);
    assign limit = (cnt == CW'(N));

endmodule

// File: rtl/libv_queue_issue.sv
// Consumer side of the speculative replay queue: pops, issues, retires on ack, replays on nack.
// Latency: one cycle from q_pop to out_vld/out_data; q_commit/q_replay/q_flush are same-cycle.
// Backpressure: out_vld/out_data hold until out_rdy; pops stop at N unresolved or during drain.
module libv_queue_issue
    import libv_pkg::*;
#(
    parameter int W = 32,
    parameter int N = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   q_empty_w,
    input  logic [W-1:0]           q_pop_data,
    output logic                   q_pop,
    output logic                   q_commit,
    output logic                   q_replay,
    output logic                   q_flush,
    output logic                   out_vld,
    output logic [W-1:0]           out_data,
    input  logic                   out_rdy,
    input  logic                   rsp_vld,
    input  logic                   rsp_ok,
    input  logic                   flush_req,
    output logic [$clog2(N+1)-1:0] inflight,
    output logic                   busy
);

    localparam int CW = $clog2(N + 1);

    state_t state_q, state_d;
    logic   empty_r;
    logic   cnt_zero, cnt_limit;
    logic   accept, is_ack, is_nack, nack_issue, issue_room;

    assign accept     = out_vld & out_rdy;
    assign is_ack     = rsp_vld & (rsp_ok == RSP_ACK);
    assign is_nack    = rsp_vld & (rsp_ok == RSP_NACK);
    assign nack_issue = (state_q == ISSUE) & is_nack;
    // inflight + out_vld < N, phrased on the counter flags to avoid a wider add
    assign issue_room = !cnt_limit & !(out_vld & (inflight == CW'(N - 1)));

    libv_queue_issue_cnt #(
        .N  (N),
        .CW (CW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (accept & !flush_req),
        .dec   (rsp_vld & !flush_req),
        .clr   (flush_req),
        .cnt   (inflight),
        .zero  (cnt_zero),
        .limit (cnt_limit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ISSUE;
            empty_r <= 1'b1;
        end else begin
            state_q <= state_d;
            empty_r <= q_empty_w;
        end
    end

    always_comb begin
        state_d  = state_q;
        q_pop    = 1'b0;
        q_commit = 1'b0;
        q_replay = 1'b0;
        q_flush  = 1'b0;
        if (flush_req) begin
            q_flush = 1'b1;
            state_d = ISSUE;
        end else begin
            case (state_q)
                ISSUE: begin
                    if (is_nack) begin
                        state_d = DRAIN;
                    end else begin
                        q_commit = is_ack;
                        q_pop    = !empty_r & (!out_vld | out_rdy) & issue_room;
                    end
                end
                DRAIN: begin
                    // the last younger response may land in the exit cycle itself
                    if (cnt_zero || ((inflight == CW'(1)) && rsp_vld)) begin
                        state_d = REPLAY;
                    end
                end
                REPLAY: begin
                    q_replay = 1'b1;
                    state_d  = ISSUE;
                end
                default: state_d = ISSUE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld  <= 1'b0;
            out_data <= '0;
        end else if (flush_req || nack_issue) begin
            out_vld <= 1'b0;
        end else if (q_pop) begin
            out_vld  <= 1'b1;
            out_data <= q_pop_data;
        end else if (accept) begin
            out_vld <= 1'b0;
        end
    end

    assign busy = (state_q != ISSUE) | !cnt_zero | out_vld;

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) rsp_vld |-> !cnt_zero);
    a_flush_quiet:  assert property (@(posedge clk) disable iff (!rst_n) flush_req |-> cnt_zero);
    a_commit_rep:   assert property (@(posedge clk) disable iff (!rst_n) !(q_commit && q_replay));
    a_pop_rep:      assert property (@(posedge clk) disable iff (!rst_n) !(q_pop && q_replay));

endmodule

// File: doc/libv_queue_issue.md
Name: libv_queue_issue

Overview:
- Consumer-side controller for the speculative replay queue.
- Pops entries into a one-entry output register and issues them downstream over a valid/ready interface.
- Tracks in-order ack/nack responses and drives the queue's pop/commit/replay/flush controls, so entries retire only on ack.
- On nack, all younger in-flight entries are replayed in order.

Parameters:
- W, 32, entry data width; matches the queue's W.
- N, 16, queue depth; also the maximum number of issued-but-unresolved entries.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- q_empty_w  in  1  queue next-cycle empty flag
- q_pop_data  in  W  queue head at speculative read pointer (current cycle)
- q_pop  out  1  advance speculative read pointer
- q_commit  out  1  advance architectural read pointer (retire one entry)
- q_replay  out  1  rewind speculative pointer to architectural pointer
- q_flush  out  1  clear queue
- out_vld  out  1  downstream entry valid
- out_data  out  W  downstream entry
- out_rdy  in  1  downstream accept
- rsp_vld  in  1  response valid; at most one per cycle, in issue order
- rsp_ok  in  1  1 = ack, 0 = nack
- flush_req  in  1  software/pipeline flush request
- inflight  out  $clog2(N+1)  issued-unresolved count
- busy  out  1  state != ISSUE or inflight != 0 or out_vld

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-low.
- Reset values: state = ISSUE, inflight = 0, out_vld = 0, out_data = 0, empty_r = 1; all q_* outputs 0.
- empty_r: registered copy of q_empty_w, i.e. the current-cycle empty flag.
- Issue condition (ISSUE state only): q_pop = !empty_r & (!out_vld | out_rdy) & (inflight + out_vld < N) & !flush_req & !nack.
  - On q_pop, out_data <= q_pop_data and out_vld <= 1 the next cycle (latency 1).
  - Otherwise, on acceptance (out_vld & out_rdy), out_vld <= 0.
- inflight arithmetic:
  - +1 on accept (out_vld & out_rdy); -1 on any rsp_vld; both in the same cycle gives net 0.
  - Saturation never occurs by construction. Underflow (rsp_vld while inflight == 0) is a protocol error, checked by an SVA.
- ISSUE state, response handling:
  - rsp_vld & rsp_ok gives q_commit = 1 (combinational, same cycle).
  - rsp_vld & !rsp_ok is a nack: no commit; out_vld is cleared next cycle (retraction is permitted only here and on flush); go to DRAIN.
- DRAIN state:
  - No pops.
  - Responses for younger entries (acks or nacks) are discarded: inflight decrements, no commit.
  - Any accept in the nack cycle still counts.
  - Exit to REPLAY when inflight == 0, or inflight == 1 with rsp_vld.
- REPLAY state: q_replay = 1 for exactly one cycle, then go to ISSUE.
  - The next pop occurs no earlier than the cycle after REPLAY; q_pop_data then shows the oldest uncommitted entry.
- Invariants:
  - q_commit and q_replay are never asserted in the same cycle. The queue's replay samples the old architectural pointer.
  - q_pop and q_replay are never asserted in the same cycle.
- Flush:
  - flush_req in any state gives q_flush = 1 the same cycle, with q_pop = q_commit = q_replay = 0.
  - Next cycle: state = ISSUE, inflight = 0, out_vld = 0.
  - Responses already outstanding at flush are a protocol error, checked by an SVA. The caller quiesces downstream before flushing.
- Priority: flush_req > nack > ack > pop.
- Asynchronous reset mid-operation returns all state to reset values immediately.
  - Queue pointers are reset by the queue itself; no replay is issued.
- Wrap-around is handled entirely by the queue pointers; this block never sees addresses.

Decomposition:
- libv_pkg: state enum (ISSUE, DRAIN, REPLAY) and the rsp encoding constants (RSP_ACK = 1, RSP_NACK = 0).
- One natural sub-module: libv_queue_issue_cnt, an up/down inflight counter with inc/dec/clr and zero/limit flags.
- FSM and output register stay in the top.

Test Plan:
- Stream: push 4 entries (0xA0..0xA3), out_rdy = 1, ack each two cycles after issue.
  - Required: out_data sequence A0..A3 with one-cycle issue latency, 4 q_commit pulses, inflight peaks at 2, and busy = 0 at the end.
- Backpressure: out_rdy = 0 for 5 cycles with 3 entries queued.
  - Required: out_vld held, out_data stable = first entry, q_pop asserted once only.
- Nack with younger in flight: issue A0..A3, ack A0, nack A1, ack A2, ack A3.
  - Required: one commit (A0), DRAIN discards 2 responses, a single q_replay pulse, then reissue A1, A2, A3 in order.
- Throttle: N = 4, no responses, 8 entries queued.
  - Required: exactly 4 accepts, then q_pop = 0; one ack releases exactly one more issue.
- Flush during DRAIN with inflight = 0 (pending REPLAY) and queue non-empty.
  - Required: q_flush pulse, no q_replay, inflight = 0, out_vld = 0 next cycle.
- Reset asserted mid-stream with out_vld = 1 and inflight = 2.
  - Required: out_vld = 0 and inflight = 0 asynchronously; all q_* outputs 0 during reset.
